// File: rtl/alu_seq.sv
// alu_seq: multicycle XLEN-wide execute-stage ALU with a start/done handshake and an
// iterative shifter moving SHIFT_STEP bits per cycle. Define ALU_SEQ_MINMAX_EN for MIN/MAX/MINU/MAXU.

`ifndef ALU_CTRL_WIDTH
`define ALU_CTRL_WIDTH 5
`define ALU_CTRL_ADD   5'd0
`define ALU_CTRL_ADDI  5'd0
`define ALU_CTRL_SUB   5'd1
`define ALU_CTRL_XOR   5'd2
`define ALU_CTRL_OR    5'd3
`define ALU_CTRL_AND   5'd4
`define ALU_CTRL_SLL   5'd5
`define ALU_CTRL_SRL   5'd6
`define ALU_CTRL_SRA   5'd7
`define ALU_CTRL_SLT   5'd8
`define ALU_CTRL_SLTI  5'd8
`define ALU_CTRL_SLTU  5'd9
`define ALU_CTRL_SLTIU 5'd9
`define ALU_CTRL_LUI   5'd10
`define ALU_CTRL_AUIPC 5'd11
`define ALU_CTRL_BEQ   5'd12
`define ALU_CTRL_BNE   5'd13
`define ALU_CTRL_BLT   5'd14
`define ALU_CTRL_BGE   5'd15
`define ALU_CTRL_BLTU  5'd16
`define ALU_CTRL_BGEU  5'd17
`define ALU_CTRL_MIN   5'd18
`define ALU_CTRL_MAX   5'd19
`define ALU_CTRL_MINU  5'd20
`define ALU_CTRL_MAXU  5'd21
`endif

module alu_seq #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [XLEN-1:0]            a,
    input  logic [XLEN-1:0]            b,
    input  logic [`ALU_CTRL_WIDTH-1:0] alucontrol,
    output logic                       busy,
    output logic                       done,
    output logic [XLEN-1:0]            result,
    output logic                       zero
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

    typedef enum logic {S_IDLE, S_SHIFT} state_e;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_e;

    state_e          state_q;
    shift_e          kind_q;
    logic [XLEN-1:0] acc_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;

    logic [CW-1:0]   shamt;
    logic [CW-1:0]   first_amt;
    logic [CW-1:0]   step_amt;
    logic [XLEN:0]   diff;
    logic            ltu;
    logic            lt;
    logic            is_shift;
    shift_e          in_kind;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] step_res;

    function automatic logic [XLEN-1:0] shift_by(input shift_e kind, input logic [XLEN-1:0] v,
                                                 input logic [CW-1:0] amt);
        case (kind)
            SH_SLL:  return v << amt;
            SH_SRL:  return v >> amt;
            default: return $signed(v) >>> amt;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] flag(input logic f);
        return {{(XLEN-1){1'b0}}, f};
    endfunction

    always_comb begin
        shamt     = {1'b0, b[SHW-1:0]};
        first_amt = (shamt > STEP_C) ? STEP_C : shamt;
        step_amt  = (cnt_q > STEP_C) ? STEP_C : cnt_q;
        step_res  = shift_by(kind_q, acc_q, step_amt);

        // Unsigned borrow is the inverted carry of a + ~b + 1; signs differing decides LT directly.
        diff = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
        ltu  = ~diff[XLEN];
        lt   = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : ltu;

        // NOTE: every combinational output gets a default first so no path can infer a latch.
        is_shift = 1'b0;
        in_kind  = SH_SLL;
        alu_res  = '0;
        case (alucontrol)
            `ALU_CTRL_ADD, `ALU_CTRL_AUIPC: alu_res = a + b;
            `ALU_CTRL_SUB:  alu_res = diff[XLEN-1:0];
            `ALU_CTRL_XOR:  alu_res = a ^ b;
            `ALU_CTRL_OR:   alu_res = a | b;
            `ALU_CTRL_AND:  alu_res = a & b;
            `ALU_CTRL_LUI:  alu_res = b;
            `ALU_CTRL_SLT, `ALU_CTRL_BLT:   alu_res = flag(lt);
            `ALU_CTRL_SLTU, `ALU_CTRL_BLTU: alu_res = flag(ltu);
            `ALU_CTRL_BEQ:  alu_res = flag(a == b);
            `ALU_CTRL_BNE:  alu_res = flag(a != b);
            `ALU_CTRL_BGE:  alu_res = flag(~lt);
            `ALU_CTRL_BGEU: alu_res = flag(~ltu);
            `ALU_CTRL_SLL: begin is_shift = 1'b1; in_kind = SH_SLL; end
            `ALU_CTRL_SRL: begin is_shift = 1'b1; in_kind = SH_SRL; end
            `ALU_CTRL_SRA: begin is_shift = 1'b1; in_kind = SH_SRA; end
`ifdef ALU_SEQ_MINMAX_EN
            `ALU_CTRL_MIN:  alu_res = lt  ? a : b;
            `ALU_CTRL_MAX:  alu_res = lt  ? b : a;
            `ALU_CTRL_MINU: alu_res = ltu ? a : b;
            `ALU_CTRL_MAXU: alu_res = ltu ? b : a;
`endif
            default: alu_res = '0;
        endcase
        // The first step is done at the accepting edge; short shifts finish right here.
        if (is_shift) alu_res = shift_by(in_kind, a, first_amt);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            kind_q   <= SH_SLL;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_shift && (shamt > STEP_C)) begin
                            acc_q   <= alu_res;
                            cnt_q   <= shamt - STEP_C;
                            kind_q  <= in_kind;
                            busy_q  <= 1'b1;
                            state_q <= S_SHIFT;
                        end else begin
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            done_q   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (cnt_q <= STEP_C) begin
                        result_q <= step_res;
                        zero_q   <= (step_res == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_IDLE;
                    end else begin
                        acc_q <= step_res;
                        cnt_q <= cnt_q - STEP_C;
                    end
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multicycle successor to the single-cycle rv32 ALU: XLEN-wide operands, registered result with a start/done handshake, and an iterative shifter that moves SHIFT_STEP bits per cycle in place of a full barrel shifter, trading area for latency on small FPGAs. It sits in the execute stage of the multicycle core. The control FSM issues `start` and holds off on `busy`, then captures `result`/`zero` on `done`.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8.
- SHIFT_STEP, 1: bits shifted per cycle; power of two, 1..XLEN.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  operation request; sampled only when `busy`=0.
- a  input  XLEN  operand A (rs1 / PC).
- b  input  XLEN  operand B (rs2 / imm); shift amount = b[$clog2(XLEN)-1:0].
- alucontrol  input  `ALU_CTRL_WIDTH  operation code, `ALU_CTRL_*` encodings from riscv_defines.vh.
- busy  output  1  multicycle shift in progress.
- done  output  1  one-cycle pulse; `result`/`zero` valid from this cycle on.
- result  output  XLEN  registered result, held until next completion.
- zero  output  1  registered (result == 0).

## Operation
- Operand A, operand B and `alucontrol` are captured at the accepting edge; later changes do not affect the operation.
- Ops supported, same semantics as the 32-bit ALU, generalised to XLEN:
  - ADD/ADDI, SUB, AUIPC: modular sum/difference.
  - XOR, OR, AND.
  - LUI: result = b.
  - SLT/SLTI, SLTU/SLTIU: 0/1.
  - Branch codes BEQ/BNE/BLT/BGE/BLTU/BGEU: 0/1 truth flag.
  - SLL, SRL, SRA.
  - MIN/MAX/MINU/MAXU: see Configuration.
  - Unlisted codes: result 0.
- Signed compare uses an (XLEN+1)-bit subtract: LT = (a[msb]^b[msb]) ? a[msb] : carry-out; LTU = carry-out of a + ~b + 1 inverted convention as in the existing ALU. The results must equal true signed/unsigned comparisons for all operands.
- FSM states: IDLE, SHIFT.
  - IDLE & start & (non-shift op or shamt==0): result computed combinationally and registered at that edge. `done`=1 next cycle. Stay IDLE.
  - IDLE & start & shift & shamt>0: acc ← a shifted by min(SHIFT_STEP, shamt), cnt ← shamt − that amount.
    - If cnt==0: done pulse, result ← acc, stay IDLE.
    - Else: go to SHIFT.
  - SHIFT: each edge acc shifted by min(SHIFT_STEP, cnt), cnt decremented by the same amount.
    - When cnt reaches 0: result ← acc, `done` pulse, go to IDLE.
- SRA fills with the captured a[XLEN-1]. SLL/SRL fill with 0.
- `start` while `busy`=1 is ignored (not queued).
- `start` in the same cycle `done`=1 is accepted (back-to-back issue).

## Timing
- Reset values: busy=0, done=0, result=0, zero=1, FSM=IDLE, cnt=0.
- Latency, start edge to `done`-high cycle:
  - 1 cycle for non-shift ops and for shamt=0.
  - L = ceil(shamt/SHIFT_STEP) cycles for shifts.
- `busy`=1 exactly in cycles 1..L-1 after the start edge. It is 0 when L=1. `busy` and `done` are never both 1.
- `done` is high for exactly one cycle per accepted `start`.
- `result`/`zero` change only on the edge that raises `done`.
- Throughput: one non-shift op per cycle.
- Reset asserted mid-shift: immediately IDLE, partial result discarded, all outputs at reset values, no `done`.
- shamt = XLEN-1 with SHIFT_STEP=1: L = XLEN-1 (31 for XLEN=32).

## Configuration
- ALU_SEQ_MINMAX_EN defined: MIN/MAX/MINU/MAXU implemented (AMO support), latency 1.
- Not defined: the compare-select muxes are removed. Those codes produce result 0 and zero=1, with normal 1-cycle `done`.

## Test plan
- Reset, then a=5, b=7, ADD, start pulse: done in cycle 1, result=12, zero=0. busy never high.
- XLEN=32, SHIFT_STEP=1, a=0x8000_0000, b=31, SRA: busy for 30 cycles, done at cycle 31, result=0xFFFF_FFFF.
- SHIFT_STEP=4, a=1, b=9, SLL: done at cycle 3, result=0x200. Extra starts during busy are ignored and produce no extra done.
- a=0xFFFF_FFFF, b=1:
  - BLT → result=1.
  - BLTU → result=0.
  - BEQ with a=b=3 → result=1.
  - SUB 3−3 → result=0, zero=1.
- rst asserted at cycle 10 of a 31-cycle shift: outputs at reset values, no done. A fresh ADD afterwards completes in 1 cycle.
- MIN a=−2, b=1:
  - With ALU_SEQ_MINMAX_EN: result=0xFFFF_FFFE.
  - Without: result=0, zero=1. Back-to-back XOR issue on consecutive cycles gives a done every cycle.
